// File: rtl/serial_mod_checker_pkg.sv
// -----------------------------------------------------------------------------
// serial_mod_checker_pkg
//
// Purpose : shared types and constants for the streaming divisibility checker.
//           Holds the checker state encoding and the width of the optional
//           digit counter.
//
// Contents:
//   state_e      - IDLE (no digits yet), ACTIVE (tracking remainder),
//                  ERR (a zero divisor was latched)
//   DIGIT_CNT_W  - width of the optional digit_cnt output
// -----------------------------------------------------------------------------
package serial_mod_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_e;

    localparam int DIGIT_CNT_W = 16;

endpackage : serial_mod_checker_pkg

// File: rtl/serial_mod_checker_mod_step_bit.sv
// -----------------------------------------------------------------------------
// mod_step_bit
//
// Purpose : one compare-subtract stage of the running-remainder update.
//           Shifts one bit into the remainder (t = 2*r + bit) and reduces it
//           modulo the divisor with a single conditional subtract. A single
//           subtract is enough because the incoming remainder is always below
//           the divisor, so t < 2*divisor.
//
// Parameters:
//   DIV_W    - divisor / remainder width
//
// Ports:
//   r_in     in  DIV_W  remainder before this bit
//   bit_in   in  1      next bit of the value (arithmetic order, MSB first)
//   divisor  in  DIV_W  modulus
//   r_out    out DIV_W  remainder after this bit
// -----------------------------------------------------------------------------
module mod_step_bit #(
    parameter int DIV_W = 8
) (
    input  logic [DIV_W-1:0] r_in,
    input  logic             bit_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] r_out
);

    // t needs one extra bit: 2*r + bit can reach 2*divisor - 1.
    logic [DIV_W:0] t;
    logic [DIV_W:0] div_ext;
    logic           ge;

    assign t       = {r_in, bit_in};
    assign div_ext = {1'b0, divisor};
    assign ge      = (t >= div_ext);

    // After reduction the result is below the divisor, so the top bit is
    // always zero and can be dropped.
    assign r_out = DIV_W'(ge ? (t - div_ext) : t);

endmodule : mod_step_bit

// File: rtl/serial_mod_checker.sv
// -----------------------------------------------------------------------------
// serial_mod_checker
//
// Purpose : streaming divisibility checker. A value of unbounded length arrives
//           most-significant digit first, DIN_W bits per accepted beat. The
//           block keeps the running remainder of the cumulative value modulo a
//           divisor that is latched with the first digit of each value, and
//           flags when that remainder is zero.
//
// Parameters:
//   DIN_W   - bits per digit (radix 2^DIN_W), 1..8
//   DIV_W   - divisor / remainder width, 2..16
//
// Optional feature (macro SERIAL_MOD_CHECKER_DIGIT_CNT_EN):
//   adds output digit_cnt, the number of digits accepted in the current value
//   (saturating, frozen while in ERR).
//
// Ports:
//   clk        in  1      clock
//   resetn     in  1      synchronous reset, active-low
//   din_valid  in  1      din carries a digit this cycle
//   din        in  DIN_W  next digit
//   divisor    in  DIV_W  divisor, sampled on the first digit of a value
//   clear      in  1      synchronous restart of the value
//   dout       out 1      cumulative value is divisible by the latched divisor
//   rem        out DIV_W  current remainder
//   busy       out 1      at least one digit accepted since reset/clear
//   err        out 1      latched divisor was zero
//   digit_cnt  out 16     (optional) digits accepted in the current value
// -----------------------------------------------------------------------------
module serial_mod_checker
    import serial_mod_checker_pkg::*;
#(
    parameter int DIN_W = 1,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] din,
    input  logic [DIV_W-1:0] divisor,
    input  logic             clear,
    output logic             dout,
    output logic [DIV_W-1:0] rem,
    output logic             busy,
    output logic             err
`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
    ,
    output logic [DIGIT_CNT_W-1:0] digit_cnt
`endif
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] div_q, div_d;

    // A digit starts a new value when nothing has been accepted yet or when
    // clear arrives together with it.
    logic             first_digit;
    logic [DIV_W-1:0] step_div;
    logic [DIV_W-1:0] step_rem_in;
    logic [DIV_W-1:0] step_rem_out;

    assign first_digit = clear || (state_q == IDLE);

    // The first digit of a value uses the divisor on the port (it is being
    // latched this same cycle) and starts from a zero remainder.
    assign step_div    = first_digit ? divisor : div_q;
    assign step_rem_in = first_digit ? '0 : rem_q;

    // Unrolled chain of DIN_W compare-subtract stages, digit MSB first.
    // Each stage owns its output wire and picks up the previous stage's
    // result by name, which keeps the chain free of array self-references.
    for (genvar i = 0; i < DIN_W; i++) begin : g_step
        logic [DIV_W-1:0] r_in_w;
        logic [DIV_W-1:0] r_out_w;

        if (i == 0) begin : g_first
            assign r_in_w = step_rem_in;
        end else begin : g_next
            assign r_in_w = g_step[i-1].r_out_w;
        end

        mod_step_bit #(
            .DIV_W (DIV_W)
        ) u_step (
            .r_in    (r_in_w),
            .bit_in  (din[DIN_W-1-i]),
            .divisor (step_div),
            .r_out   (r_out_w)
        );
    end

    assign step_rem_out = g_step[DIN_W-1].r_out_w;

    // Next-state logic. Priority: clear without a digit returns to IDLE;
    // otherwise an accepted digit either starts a new value (latching the
    // divisor, or falling into ERR on zero) or extends the current one.
    // ERR only exits through clear or reset.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;

        if (clear && !din_valid) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (din_valid) begin
            if (first_digit) begin
                div_d = divisor;
                if (divisor == '0) begin
                    state_d = ERR;
                    rem_d   = '0;
                end else begin
                    state_d = ACTIVE;
                    rem_d   = step_rem_out;
                end
            end else if (state_q == ACTIVE) begin
                rem_d = step_rem_out;
            end
        end
    end

    // State registers; reset wins over clear and din_valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
        end
    end

`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
    logic [DIGIT_CNT_W-1:0] cnt_q, cnt_d;

    // Counts digits of the current value. The first digit of a value always
    // loads 1 (including one that lands in ERR); after that the count only
    // advances while ACTIVE and sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear && !din_valid) begin
            cnt_d = '0;
        end else if (din_valid) begin
            if (first_digit) begin
                cnt_d = {{(DIGIT_CNT_W-1){1'b0}}, 1'b1};
            end else if ((state_q == ACTIVE) && (cnt_q != '1)) begin
                cnt_d = cnt_q + {{(DIGIT_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign digit_cnt = cnt_q;
`endif

    // All outputs come straight from registers.
    assign dout = (state_q == ACTIVE) && (rem_q == '0);
    assign rem  = rem_q;
    assign busy = (state_q != IDLE);
    assign err  = (state_q == ERR);

endmodule : serial_mod_checker

// File: tb/tb_serial_mod_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_mod_checker
//
// Purpose : self-checking bench for serial_mod_checker. Two instances share
//           the control inputs: one with 1-bit digits, one with 4-bit digits
//           (the 1-bit instance sees bit 0 of each digit). A behavioural model
//           built on plain integer arithmetic predicts every output; its
//           predictions are queued when stimulus is driven and compared after
//           the following clock edge.
//
// Optional feature (macro SERIAL_MOD_CHECKER_DIGIT_CNT_EN): digit_cnt is
// connected and checked as well.
// -----------------------------------------------------------------------------
module tb_serial_mod_checker;

    localparam int DIV_W = 8;

    logic             clk       = 1'b0;
    logic             resetn    = 1'b0;
    logic             din_valid = 1'b0;
    logic             clear     = 1'b0;
    logic [3:0]       din4      = 4'd0;
    logic [0:0]       din1;
    logic [DIV_W-1:0] divisor   = '0;

    logic             dout1, busy1, err1;
    logic [DIV_W-1:0] rem1;
    logic             dout4, busy4, err4;
    logic [DIV_W-1:0] rem4;
`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
    logic [15:0]      cnt1, cnt4;
`endif

    int vectors     = 0;
    int miscompares = 0;

    assign din1 = din4[0:0];

    always #5 clk = ~clk;

    serial_mod_checker #(
        .DIN_W (1),
        .DIV_W (DIV_W)
    ) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid),
        .din       (din1),
        .divisor   (divisor),
        .clear     (clear),
        .dout      (dout1),
        .rem       (rem1),
        .busy      (busy1),
        .err       (err1)
`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
        ,
        .digit_cnt (cnt1)
`endif
    );

    serial_mod_checker #(
        .DIN_W (4),
        .DIV_W (DIV_W)
    ) dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid),
        .din       (din4),
        .divisor   (divisor),
        .clear     (clear),
        .dout      (dout4),
        .rem       (rem4),
        .busy      (busy4),
        .err       (err4)
`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
        ,
        .digit_cnt (cnt4)
`endif
    );

    // Reference model state, index 0 = 1-bit digits, index 1 = 4-bit digits.
    // m_state: 0 idle, 1 active, 2 err.
    int m_state [2];
    int m_rem   [2];
    int m_div   [2];
    int m_cnt   [2];
    int m_width [2] = '{1, 4};

    typedef struct {
        int id;
        int rem;
        int dout;
        int busy;
        int err;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advances the model of one instance by one clock edge.
    task automatic modelStep(input int id, input logic v, input int d,
                             input int dv, input logic clr, input logic rstn);
        int digit;
        digit = d % (1 << m_width[id]);
        if (!rstn) begin
            m_state[id] = 0;
            m_rem[id]   = 0;
            m_div[id]   = 0;
            m_cnt[id]   = 0;
        end else if (clr && !v) begin
            m_state[id] = 0;
            m_rem[id]   = 0;
            m_cnt[id]   = 0;
        end else if (v && (clr || m_state[id] == 0)) begin
            m_div[id] = dv;
            m_cnt[id] = 1;
            if (dv == 0) begin
                m_state[id] = 2;
                m_rem[id]   = 0;
            end else begin
                m_state[id] = 1;
                m_rem[id]   = digit % dv;
            end
        end else if (v && m_state[id] == 1) begin
            m_rem[id] = (m_rem[id] * (1 << m_width[id]) + digit) % m_div[id];
            if (m_cnt[id] < 65535) m_cnt[id] = m_cnt[id] + 1;
        end
    endtask

    // Drives one cycle of stimulus, queues the model predictions, then checks
    // both instances just after the clock edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d,
                                 input logic [7:0] dv, input logic clr,
                                 input logic rstn);
        exp_t e;
        din_valid = v;
        din4      = d;
        divisor   = dv;
        clear     = clr;
        resetn    = rstn;
        for (int id = 0; id < 2; id++) begin
            modelStep(id, v, int'(d), int'(dv), clr, rstn);
            e.id   = id;
            e.rem  = m_rem[id];
            e.dout = (m_state[id] == 1 && m_rem[id] == 0) ? 1 : 0;
            e.busy = (m_state[id] != 0) ? 1 : 0;
            e.err  = (m_state[id] == 2) ? 1 : 0;
            e.cnt  = m_cnt[id];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.id == 0) begin
                checkOutput("rem1",  int'(rem1),  e.rem);
                checkOutput("dout1", int'(dout1), e.dout);
                checkOutput("busy1", int'(busy1), e.busy);
                checkOutput("err1",  int'(err1),  e.err);
`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
                checkOutput("cnt1",  int'(cnt1),  e.cnt);
`endif
            end else begin
                checkOutput("rem4",  int'(rem4),  e.rem);
                checkOutput("dout4", int'(dout4), e.dout);
                checkOutput("busy4", int'(busy4), e.busy);
                checkOutput("err4",  int'(err4),  e.err);
`ifdef SERIAL_MOD_CHECKER_DIGIT_CNT_EN
                checkOutput("cnt4",  int'(cnt4),  e.cnt);
`endif
            end
        end
    endtask

    logic [3:0] bits_a   [4] = '{4'd1, 4'd1, 4'd0, 4'd1};
    logic [3:0] digits_b [3] = '{4'h1, 4'h5, 4'hF};

    initial begin
        for (int id = 0; id < 2; id++) begin
            m_state[id] = 0;
            m_rem[id]   = 0;
            m_div[id]   = 0;
            m_cnt[id]   = 0;
        end

        // Reset state, with a digit present that must be discarded.
        applyStimulus(1'b1, 4'h3, 8'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 8'd3, 1'b1, 1'b0);

        // Divide by 3, bits 1,1,0,1.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, bits_a[i], 8'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'h0, 8'd3, 1'b1, 1'b1);

        // Divide by 7, digits 1,5,F; divisor port moves to 5 after the first.
        applyStimulus(1'b1, digits_b[0], 8'd7, 1'b0, 1'b1);
        applyStimulus(1'b1, digits_b[1], 8'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, digits_b[2], 8'd5, 1'b0, 1'b1);
        checkOutput("plan_rem4_351", int'(rem4), 1);
        applyStimulus(1'b0, 4'h0, 8'd5, 1'b1, 1'b1);

        // Zero divisor, stays in ERR, then clear+valid restarts with /3.
        applyStimulus(1'b1, 4'h2, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h3, 8'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h4, 8'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h3, 8'd3, 1'b1, 1'b1);
        checkOutput("plan_dout4_restart", int'(dout4), 1);

        // Gap of 5 idle cycles, then the value continues.
        applyStimulus(1'b1, 4'h7, 8'd9, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'hA, 8'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h2, 8'd2, 1'b0, 1'b1);

        // Mid-stream reset with a digit on the bus, then digit 1.
        applyStimulus(1'b1, 4'h1, 8'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h1, 8'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h6, 8'd5, 1'b0, 1'b1);

        // Divisor 1, then a value starting with a leading zero digit.
        applyStimulus(1'b1, 4'h9, 8'd1, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'hB, 8'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h0, 8'd13, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'hD, 8'd13, 1'b0, 1'b1);

        // Divisors at the top of the range.
        applyStimulus(1'b1, 4'hF, 8'd255, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'hF, 8'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'hE, 8'd254, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'hF, 8'd2, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(3) != 0),
                          4'($urandom_range(15)),
                          8'(($urandom_range(7) == 0) ? $urandom_range(255) : $urandom_range(11)),
                          ($urandom_range(9) == 0),
                          ($urandom_range(39) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_mod_checker

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
Parametrised streaming divisibility checker. A value of unbounded length arrives most-significant digit first, DIN_W bits per accepted beat. The block tracks the running remainder modulo a runtime-selectable divisor and flags when the cumulative value is evenly divisible. It generalises the fixed divide-by-3, 1-bit-per-cycle checker with a wider digit, a programmable divisor, a valid qualifier, a clear input and a remainder output.

Parameters:
DIN_W, 1, bits shifted in per accepted beat (radix 2^DIN_W); legal range 1..8
DIV_W, 8, divisor and remainder width; legal range 2..16

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
din_valid  in  1  din carries a digit this cycle
din  in  DIN_W  next digit, MSB of digit first in arithmetic order
divisor  in  DIV_W  divisor, sampled only on the first accepted digit of a value
clear  in  1  synchronous restart of the value without full reset
dout  out  1  1 when the cumulative value mod the latched divisor == 0
rem  out  DIV_W  current remainder
busy  out  1  at least one digit accepted since reset/clear
err  out  1  latched divisor was 0

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, rem=0, divisor latch=0. Outputs dout=0, rem=0, busy=0, err=0. Reset overrides clear and din_valid. The digit present during reset is discarded.
- FSM states:
  - IDLE: no digits yet. dout=0.
  - ACTIVE: tracking the remainder.
  - ERR: divisor==0 was latched.
- IDLE + din_valid:
  - Latch divisor.
  - divisor==0 -> ERR.
  - else rem <= step(0, din) and -> ACTIVE.
- ACTIVE + din_valid: rem <= step(rem, din), using the latched divisor. The divisor port is ignored.
- din_valid=0: state and rem hold.
- clear=1 from any non-reset state:
  - Without din_valid -> IDLE, rem=0.
  - With din_valid: the digit is the first digit of a new value; the divisor is re-sampled and the same IDLE rules apply.
- ERR: holds until reset or clear. rem=0, dout=0, err=1.
- step(r, d) definition:
  - Process the DIN_W bits of d from MSB to LSB.
  - Each bit: t = 2*r + bit, computed at DIV_W+1 bits.
  - If t >= divisor, r = t - divisor; else r = t.
  - Because the invariant r < divisor holds, one conditional subtract per bit suffices. The stages are unrolled combinationally.
- Outputs are driven from registers only:
  - dout = (state==ACTIVE) && (rem==0).
  - busy = (state != IDLE).
  - Latency: digit accepted at edge k is reflected in dout/rem immediately after edge k.
- Divisor 1: rem always 0, dout=1 after the first digit.
- A leading zero digit still moves the state to ACTIVE with dout=1 (value 0 is divisible).

Optional Feature:
- Macro: SERIAL_MOD_CHECKER_DIGIT_CNT_EN.
- When defined: adds output digit_cnt [15:0], the count of digits accepted in the current value.
  - Cleared by reset and by clear. When clear coincides with din_valid, it loads 1.
  - Saturates at 16'hFFFF.
  - Does not increment in ERR.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package serial_mod_checker_pkg:
  - state enum (IDLE, ACTIVE, ERR).
  - Localparam DIGIT_CNT_W=16.
- Sub-module mod_step_bit: one compare-subtract stage (r, bit, divisor -> r_next). It is instantiated DIN_W times in a generate chain inside serial_mod_checker.

Test Plan:
- DIN_W=1, divisor=3, bits 1,1,0,1 -> rem 1,0,0,1; dout 0,1,1,0.
- DIN_W=4, divisor=7, digits 0x1,0x5,0xF:
  - Values 1, 21, 351 -> rem 1, 0, 1; dout 0, 1, 0.
  - Divisor port changed to 5 mid-stream has no effect.
- divisor=0 with the first digit -> err=1, dout=0, stays in ERR across further digits. Clear+valid with divisor=3 and digit 0x3 -> err=0, rem=0, dout=1.
- Gaps: din_valid low for 5 cycles between digits -> rem/dout unchanged across the gap. Next digit continues the same value.
- Mid-stream resetn=0 for 1 cycle with din=1 -> dout=0, busy=0. The next digit 1 gives rem=1 (the reset-cycle digit is not counted).
- With SERIAL_MOD_CHECKER_DIGIT_CNT_EN: 3 digits -> digit_cnt=3. clear+valid -> digit_cnt=1.
